// File: rtl/cnn_pkg.sv
// Shared fixed-point types and the backprop sequencer state encoding.
package cnn_pkg;

   localparam int FRAC_BITS = 8;

   typedef logic signed [15:0] q8_8_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      UPDATE,
      DONE
   } state_t;

endpackage

// File: rtl/fixed_point_multiplier.sv
// Combinational Q8.8 x Q8.8 multiply, result rescaled to Q8.8 with 16-bit wrap.
module fixed_point_multiplier
   import cnn_pkg::*;
(
   input  q8_8_t a,
   input  q8_8_t b,
   output q8_8_t product
);

   logic signed [31:0] full;

   always_comb begin
      full    = 32'(a) * 32'(b);
      product = q8_8_t'(full >>> FRAC_BITS);
   end

endmodule

// File: rtl/conv2d_backprop_seq.sv
// Sequential kernel-gradient accumulation and SGD kernel update for one conv layer.
module conv2d_backprop_seq
   import cnn_pkg::*;
#(
   parameter  int IN_SIZE     = 4,
   parameter  int KERNEL_SIZE = 3,
   localparam int OUT_SIZE    = IN_SIZE - KERNEL_SIZE + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic signed [15:0] input_feature [IN_SIZE][IN_SIZE],
   input  logic signed [15:0] conv_out      [OUT_SIZE][OUT_SIZE],
   input  logic signed [15:0] dL_drelu      [OUT_SIZE][OUT_SIZE],
   input  logic signed [15:0] learning_rate,
   input  logic signed [15:0] kernel_in     [KERNEL_SIZE][KERNEL_SIZE],
   output logic signed [15:0] kernel_out    [KERNEL_SIZE][KERNEL_SIZE],
   output logic signed [15:0] grad_out      [KERNEL_SIZE][KERNEL_SIZE],
   output logic               busy,
   output logic               done
);

   localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

   state_t state_q, state_d;

   logic [KW-1:0] m_q, m_d, n_q, n_d;
   logic [OW-1:0] i_q, i_d, j_q, j_d;
   logic signed [31:0] acc_q, acc_d;
   logic done_q, done_d;

   q8_8_t feat_q [IN_SIZE][IN_SIZE];
   q8_8_t feat_d [IN_SIZE][IN_SIZE];
   q8_8_t g_q    [OUT_SIZE][OUT_SIZE];
   q8_8_t g_d    [OUT_SIZE][OUT_SIZE];
   q8_8_t kern_q [KERNEL_SIZE][KERNEL_SIZE];
   q8_8_t kern_d [KERNEL_SIZE][KERNEL_SIZE];
   q8_8_t grad_q [KERNEL_SIZE][KERNEL_SIZE];
   q8_8_t grad_d [KERNEL_SIZE][KERNEL_SIZE];
   q8_8_t kout_q [KERNEL_SIZE][KERNEL_SIZE];
   q8_8_t kout_d [KERNEL_SIZE][KERNEL_SIZE];
   q8_8_t lr_q, lr_d;

   logic j_last, i_last, n_last, m_last, pos_last, tap_last;
   logic [IW-1:0] row, col;
   logic signed [31:0] prod, acc_sum;
   q8_8_t step;

   always_comb begin
      j_last   = (j_q == OW'(OUT_SIZE - 1));
      i_last   = (i_q == OW'(OUT_SIZE - 1));
      n_last   = (n_q == KW'(KERNEL_SIZE - 1));
      m_last   = (m_q == KW'(KERNEL_SIZE - 1));
      pos_last = i_last && j_last;
      tap_last = m_last && n_last;
      row      = IW'(m_q) + IW'(i_q);
      col      = IW'(n_q) + IW'(j_q);
   end

   // The UPDATE phase shares one multiplier across taps via the m/n counters.
   fixed_point_multiplier u_update_mul (
      .a       (lr_q),
      .b       (grad_q[m_q][n_q]),
      .product (step)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ACCUM;
         ACCUM:   if (tap_last && pos_last) state_d = UPDATE;
         UPDATE:  if (tap_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy       = (state_q != IDLE);
      done       = done_q;
      grad_out   = grad_q;
      kernel_out = kout_q;
   end

   always_comb begin
      m_d    = m_q;
      n_d    = n_q;
      i_d    = i_q;
      j_d    = j_q;
      acc_d  = acc_q;
      feat_d = feat_q;
      g_d    = g_q;
      kern_d = kern_q;
      lr_d   = lr_q;
      grad_d = grad_q;
      kout_d = kout_q;

      prod    = 32'(feat_q[row][col]) * 32'(g_q[i_q][j_q]);
      acc_sum = acc_q + prod;

      case (state_q)
         IDLE: begin
            if (start) begin
               feat_d = input_feature;
               kern_d = kernel_in;
               lr_d   = learning_rate;
               for (int unsigned r = 0; r < OUT_SIZE; r++)
                  for (int unsigned c = 0; c < OUT_SIZE; c++)
                     g_d[r][c] = conv_out[r][c][15] ? '0 : dL_drelu[r][c];
               acc_d = '0;
               m_d   = '0;
               n_d   = '0;
               i_d   = '0;
               j_d   = '0;
            end
         end
         ACCUM: begin
            // Writing the final sum and zeroing acc on the same edge clears it for the next tap.
            if (pos_last) begin
               acc_d            = '0;
               grad_d[m_q][n_q] = q8_8_t'(acc_sum >>> FRAC_BITS);
            end else begin
               acc_d = acc_sum;
            end
            j_d = j_q + OW'(1);
            if (j_last) begin
               j_d = '0;
               i_d = i_q + OW'(1);
               if (i_last) begin
                  i_d = '0;
                  n_d = n_q + KW'(1);
                  if (n_last) begin
                     n_d = '0;
                     m_d = m_last ? '0 : m_q + KW'(1);
                  end
               end
            end
         end
         UPDATE: begin
            kout_d[m_q][n_q] = kern_q[m_q][n_q] - step;
            n_d = n_q + KW'(1);
            if (n_last) begin
               n_d = '0;
               m_d = m_last ? '0 : m_q + KW'(1);
            end
         end
         default: ;
      endcase

      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_q    <= '0;
         n_q    <= '0;
         i_q    <= '0;
         j_q    <= '0;
         acc_q  <= '0;
         done_q <= 1'b0;
         lr_q   <= '0;
         feat_q <= '{default: '0};
         g_q    <= '{default: '0};
         kern_q <= '{default: '0};
         grad_q <= '{default: '0};
         kout_q <= '{default: '0};
      end else begin
         m_q    <= m_d;
         n_q    <= n_d;
         i_q    <= i_d;
         j_q    <= j_d;
         acc_q  <= acc_d;
         done_q <= done_d;
         lr_q   <= lr_d;
         feat_q <= feat_d;
         g_q    <= g_d;
         kern_q <= kern_d;
         grad_q <= grad_d;
         kout_q <= kout_d;
      end
   end

endmodule

// File: tb/tb_conv2d_backprop_seq.sv
// Scoreboard bench: stimulus queues expected results, a done-driven monitor checks them.
module tb_conv2d_backprop_seq;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic signed [15:0] feat [4][4];
   logic signed [15:0] co   [2][2];
   logic signed [15:0] dl   [2][2];
   logic signed [15:0] lr;
   logic signed [15:0] kin  [3][3];
   logic signed [15:0] kout [3][3];
   logic signed [15:0] grad [3][3];
   logic busy, done;

   conv2d_backprop_seq #(.IN_SIZE(4), .KERNEL_SIZE(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .input_feature (feat),
      .conv_out      (co),
      .dL_drelu      (dl),
      .learning_rate (lr),
      .kernel_in     (kin),
      .kernel_out    (kout),
      .grad_out      (grad),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [8:0][15:0] g;
      logic [8:0][15:0] k;
      logic [31:0]      cyc;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk_uniform(input logic [15:0] g, input logic [15:0] k,
                                       input logic [31:0] c);
      exp_t e;
      for (int t = 0; t < 9; t++) begin
         e.g[t] = g;
         e.k[t] = k;
      end
      e.cyc = c;
      return e;
   endfunction

   function automatic exp_t mk_ramp(input logic [31:0] c);
      exp_t e;
      logic [15:0] v;
      for (int m = 0; m < 3; m++)
         for (int n = 0; n < 3; n++) begin
            v = 16'((2 * (4 * m + n)) << 8);
            e.g[m*3+n] = v;
            e.k[m*3+n] = ~v + 16'd1;
         end
      e.cyc = c;
      return e;
   endfunction

   // Monitor: every done pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (cyc != e.cyc) begin
               n_fail++;
               $display("FAIL done_cycle: got %0d expected %0d", cyc, e.cyc);
            end
            for (int m = 0; m < 3; m++)
               for (int n = 0; n < 3; n++) begin
                  check($sformatf("grad_out[%0d][%0d]", m, n), {16'h0, grad[m][n]}, {16'h0, e.g[m*3+n]});
                  check($sformatf("kernel_out[%0d][%0d]", m, n), {16'h0, kout[m][n]}, {16'h0, e.k[m*3+n]});
               end
         end
      end
   end

   task automatic set_uniform(input logic [15:0] f, input logic [15:0] c, input logic [15:0] d,
                              input logic [15:0] l, input logic [15:0] k);
      for (int r = 0; r < 4; r++)
         for (int q = 0; q < 4; q++) feat[r][q] = f;
      for (int r = 0; r < 2; r++)
         for (int q = 0; q < 2; q++) begin
            co[r][q] = c;
            dl[r][q] = d;
         end
      for (int r = 0; r < 3; r++)
         for (int q = 0; q < 3; q++) kin[r][q] = k;
      lr = l;
   endtask

   task automatic set_ramp();
      set_uniform(16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000);
      for (int r = 0; r < 4; r++)
         for (int q = 0; q < 4; q++) feat[r][q] = 16'((4 * r + q) << 8);
      dl[0][0] = 16'h0200;
   endtask

   task automatic pulse_start(output int unsigned s);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 s = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int unsigned k;
      k = 0;
      while (sb.size() != 0 && k < 300) begin
         @(posedge clk);
         k++;
      end
      check(name, sb.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_cleared(input string tag);
      for (int m = 0; m < 3; m++)
         for (int n = 0; n < 3; n++) begin
            check({tag, "_grad"}, {16'h0, grad[m][n]}, 32'h0);
            check({tag, "_kout"}, {16'h0, kout[m][n]}, 32'h0);
         end
      check({tag, "_busy"}, {31'h0, busy}, 32'h0);
      check({tag, "_done"}, {31'h0, done}, 32'h0);
   endtask

   initial begin
      int unsigned s;
      int unsigned lows;

      rst   = 1'b1;
      start = 1'b0;
      set_uniform(16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0100);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_cleared("reset");
      rst = 1'b0;

      // Uniform ones: grad 4.0, kernel 1.0 - 0.5*4.0
      set_uniform(16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0100);
      pulse_start(s);
      sb.push_back(mk_uniform(16'h0400, 16'hFF00, s + 45));
      wait_drain("drain_uniform");

      // Negative pre-activation masks every gradient
      set_uniform(16'h0100, 16'hFF00, 16'h0100, 16'h0080, 16'h0100);
      pulse_start(s);
      sb.push_back(mk_uniform(16'h0000, 16'h0100, s + 45));
      wait_drain("drain_masked");

      set_ramp();
      pulse_start(s);
      sb.push_back(mk_ramp(s + 45));
      wait_drain("drain_ramp");

      // Re-pulsed start with different operands mid-pass must be ignored
      set_uniform(16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0100);
      pulse_start(s);
      sb.push_back(mk_uniform(16'h0400, 16'hFF00, s + 45));
      while (cyc < s + 9) @(negedge clk);
      set_uniform(16'h0300, 16'h0100, 16'h0200, 16'h0100, 16'h0200);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_drain("drain_restart");

      // Reset at edge 20 aborts without done; outputs clear
      set_uniform(16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0100);
      pulse_start(s);
      while (cyc < s + 19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_cleared("abort");
      rst = 1'b0;
      repeat (60) @(negedge clk);
      set_ramp();
      pulse_start(s);
      sb.push_back(mk_ramp(s + 45));
      wait_drain("drain_after_abort");

      // Start held high: back-to-back passes, one idle cycle between them
      set_uniform(16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0100);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 s = cyc;
      sb.push_back(mk_uniform(16'h0400, 16'hFF00, s + 45));
      sb.push_back(mk_uniform(16'h0400, 16'hFF00, s + 92));
      lows = 0;
      for (int k = 0; k <= 92; k++) begin
         @(negedge clk);
         if (busy !== 1'b1) lows++;
      end
      start = 1'b0;
      check("busy_low_cycles", lows, 1);
      wait_drain("drain_held_start");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
